// File: rtl/psram_arbiter.sv
// Two-port PSRAM arbiter: a video read stream and a host read/write port share one
// PSRAM controller, with bounded video streaks and a per-transaction watchdog.
module psram_arbiter #(
  parameter int ADDR_W         = 24,
  parameter int DATA_W         = 16,
  parameter int MAX_VID_STREAK = 4,
  parameter int TIMEOUT        = 1023
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  // video read port
  input  logic              i_vid_req,
  input  logic [ADDR_W-1:0] i_vid_addr,
  output logic              o_vid_ack,
  output logic              o_vid_valid,
  output logic [DATA_W-1:0] o_vid_data,
  // host read/write port
  input  logic              i_host_req,
  input  logic              i_host_we,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [DATA_W-1:0] i_host_din,
  output logic              o_host_ack,
  output logic              o_host_valid,
  output logic [DATA_W-1:0] o_host_data,
  // PSRAM controller side
  output logic              o_psram_stb,
  output logic              o_psram_we,
  output logic [ADDR_W-1:0] o_psram_addr,
  output logic [DATA_W-1:0] o_psram_din,
  input  logic              i_psram_busy,
  input  logic              i_psram_done,
  input  logic [DATA_W-1:0] i_psram_dout,
  // status
  output logic              o_err,
  output logic [1:0]        o_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  localparam int SW = $clog2(MAX_VID_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_e            state_q;
  logic              owner_host_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic              stb_q;
  logic              vid_ack_q, host_ack_q;
  logic              vid_valid_q, host_valid_q;
  logic [DATA_W-1:0] vid_data_q, host_data_q;
  logic              err_q;
  logic [SW-1:0]     streak_q, streak_d;
  logic [TW-1:0]     tmo_q, tmo_d;

  logic vid_win, host_win, grant, abort, done_ok;

  // Video keeps priority until it has starved a waiting host MAX_VID_STREAK times.
  assign vid_win  = i_vid_req && ((streak_q < SW'(MAX_VID_STREAK)) || !i_host_req);
  assign host_win = i_host_req && !vid_win;
  assign grant    = (state_q == IDLE) && !i_psram_busy && (vid_win || host_win);

  always_comb begin
    streak_d = '0;
    if (vid_win && i_host_req)
      streak_d = (streak_q == SW'(MAX_VID_STREAK)) ? streak_q : streak_q + 1'b1;
  end

  assign tmo_d   = tmo_q + 1'b1;
  assign abort   = (state_q != IDLE) && (tmo_d == TW'(TIMEOUT));
  assign done_ok = (state_q == WAIT_DONE) && i_psram_done && !abort;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= IDLE;
      owner_host_q <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      din_q        <= '0;
      stb_q        <= 1'b0;
      vid_ack_q    <= 1'b0;
      host_ack_q   <= 1'b0;
      vid_valid_q  <= 1'b0;
      host_valid_q <= 1'b0;
      vid_data_q   <= '0;
      host_data_q  <= '0;
      err_q        <= 1'b0;
      streak_q     <= '0;
      tmo_q        <= '0;
    end else begin
      vid_ack_q    <= 1'b0;
      host_ack_q   <= 1'b0;
      vid_valid_q  <= 1'b0;
      host_valid_q <= 1'b0;
      if (abort || done_ok) begin
        // Abort reports zero data so the owner is never left waiting forever.
        state_q <= IDLE;
        stb_q   <= 1'b0;
        if (abort) err_q <= 1'b1;
        if (owner_host_q) begin
          host_valid_q <= 1'b1;
          if (abort)      host_data_q <= '0;
          else if (!we_q) host_data_q <= i_psram_dout;
        end else begin
          vid_valid_q <= 1'b1;
          vid_data_q  <= abort ? '0 : i_psram_dout;
        end
      end else if (state_q == ISSUE && i_psram_busy) begin
        stb_q   <= 1'b0;
        state_q <= WAIT_DONE;
        tmo_q   <= tmo_d;
      end else if (state_q != IDLE) begin
        tmo_q <= tmo_d;
      end else if (grant) begin
        owner_host_q <= host_win;
        we_q         <= host_win & i_host_we;
        addr_q       <= host_win ? i_host_addr : i_vid_addr;
        din_q        <= host_win ? i_host_din : '0;
        stb_q        <= 1'b1;
        vid_ack_q    <= vid_win;
        host_ack_q   <= host_win;
        streak_q     <= streak_d;
        tmo_q        <= '0;
        state_q      <= ISSUE;
      end
    end
  end

  assign o_vid_ack    = vid_ack_q;
  assign o_vid_valid  = vid_valid_q;
  assign o_vid_data   = vid_data_q;
  assign o_host_ack   = host_ack_q;
  assign o_host_valid = host_valid_q;
  assign o_host_data  = host_data_q;
  assign o_psram_stb  = stb_q;
  assign o_psram_we   = stb_q & we_q;
  assign o_psram_addr = addr_q;
  assign o_psram_din  = din_q;
  assign o_err        = err_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// Scoreboard bench for psram_arbiter: stimulus pushes expected grants, PSRAM strobes
// and completions; an independent negedge monitor pops and compares them.
module tb_psram_arbiter;
  localparam int AW = 24;
  localparam int DW = 16;

  logic          i_clk = 1'b0;
  logic          i_rstn;
  logic          i_vid_req, i_host_req, i_host_we;
  logic [AW-1:0] i_vid_addr, i_host_addr;
  logic [DW-1:0] i_host_din;
  logic          o_vid_ack, o_vid_valid, o_host_ack, o_host_valid;
  logic [DW-1:0] o_vid_data, o_host_data;
  logic          o_psram_stb, o_psram_we;
  logic [AW-1:0] o_psram_addr;
  logic [DW-1:0] o_psram_din;
  logic          i_psram_busy, i_psram_done;
  logic [DW-1:0] i_psram_dout;
  logic          o_err;
  logic [1:0]    o_state;

  logic model_busy, force_busy, model_en;
  assign i_psram_busy = model_busy | force_busy;

  psram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_VID_STREAK(4), .TIMEOUT(1023)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_vid_req(i_vid_req), .i_vid_addr(i_vid_addr),
    .o_vid_ack(o_vid_ack), .o_vid_valid(o_vid_valid), .o_vid_data(o_vid_data),
    .i_host_req(i_host_req), .i_host_we(i_host_we), .i_host_addr(i_host_addr),
    .i_host_din(i_host_din),
    .o_host_ack(o_host_ack), .o_host_valid(o_host_valid), .o_host_data(o_host_data),
    .o_psram_stb(o_psram_stb), .o_psram_we(o_psram_we), .o_psram_addr(o_psram_addr),
    .o_psram_din(o_psram_din),
    .i_psram_busy(i_psram_busy), .i_psram_done(i_psram_done), .i_psram_dout(i_psram_dout),
    .o_err(o_err), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } psram_exp_t;

  logic          grant_q[$];   // 1 = host
  psram_exp_t    psram_q[$];
  logic [DW-1:0] host_q[$];
  logic [DW-1:0] vid_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int stb_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got unexpected output, expected none", nm);
  endtask

  task automatic push_txn(input logic host, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] resp);
    psram_exp_t p;
    p.we = we; p.addr = a; p.din = d;
    grant_q.push_back(host);
    psram_q.push_back(p);
    if (host) host_q.push_back(resp);
    else      vid_q.push_back(resp);
  endtask

  // PSRAM controller model: busy for two cycles after a strobe, then a one-cycle done.
  logic [DW-1:0] mem [logic [AW-1:0]];
  initial begin
    logic [DW-1:0] rd;
    logic [AW-1:0] a;
    model_busy   = 1'b0;
    i_psram_done = 1'b0;
    i_psram_dout = '0;
    forever begin
      @(posedge i_clk); #1;
      if (model_en && i_rstn && o_psram_stb) begin
        a = o_psram_addr;
        if (o_psram_we) begin
          mem[a] = o_psram_din;
          rd = 16'hDEAD;
        end else begin
          rd = mem.exists(a) ? mem[a] : {a[7:0], 8'hA5};
        end
        model_busy = 1'b1;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        model_busy   = 1'b0;
        i_psram_done = 1'b1;
        i_psram_dout = rd;
        @(posedge i_clk); #1;
        i_psram_done = 1'b0;
      end
    end
  end

  // Monitor
  initial begin
    logic stb_prev = 1'b0;
    logic g;
    psram_exp_t p;
    forever begin
      @(negedge i_clk);
      if (i_rstn) begin
        if (o_psram_stb) stb_total++;
        if (o_vid_ack || o_host_ack) begin
          if (grant_q.size() == 0) unexpected("grant");
          else begin
            g = grant_q.pop_front();
            chk("grant_owner_host", {31'd0, o_host_ack}, {31'd0, g});
            chk("grant_ack_onehot", {31'd0, o_host_ack & o_vid_ack}, 32'd0);
          end
        end
        if (o_psram_stb && !stb_prev) begin
          if (psram_q.size() == 0) unexpected("psram_stb");
          else begin
            p = psram_q.pop_front();
            chk("psram_we", {31'd0, o_psram_we}, {31'd0, p.we});
            chk("psram_addr", {8'd0, o_psram_addr}, {8'd0, p.addr});
            if (p.we) chk("psram_din", {16'd0, o_psram_din}, {16'd0, p.din});
          end
        end
        if (o_host_valid) begin
          if (host_q.size() == 0) unexpected("host_valid");
          else chk("host_data", {16'd0, o_host_data}, {16'd0, host_q.pop_front()});
        end
        if (o_vid_valid) begin
          if (vid_q.size() == 0) unexpected("vid_valid");
          else chk("vid_data", {16'd0, o_vid_data}, {16'd0, vid_q.pop_front()});
        end
      end
      stb_prev = o_psram_stb;
    end
  end

  task automatic wait_valid(input logic host, input int lim);
    int n = 0;
    while (!(host ? o_host_valid : o_vid_valid) && n < lim) begin
      @(posedge i_clk); #1;
      n++;
    end
    chk(host ? "host_valid_seen" : "vid_valid_seen",
        {31'd0, host ? o_host_valid : o_vid_valid}, 32'd1);
  endtask

  task automatic wait_ack(input logic host);
    int n = 0;
    do begin
      @(posedge i_clk); #1;
      n++;
    end while (!(host ? o_host_ack : o_vid_ack) && n < 50);
    chk(host ? "host_ack_seen" : "vid_ack_seen",
        {31'd0, host ? o_host_ack : o_vid_ack}, 32'd1);
  endtask

  task automatic host_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int lim);
    i_host_req = 1'b1; i_host_we = we; i_host_addr = a; i_host_din = d;
    wait_ack(1'b1);
    i_host_req = 1'b0;
    wait_valid(1'b1, lim);
  endtask

  task automatic vid_txn(input logic [AW-1:0] a);
    i_vid_req = 1'b1; i_vid_addr = a;
    wait_ack(1'b0);
    i_vid_req = 1'b0;
    wait_valid(1'b0, 50);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks, n, s0;
    logic seen;
    i_rstn = 1'b1; i_vid_req = 1'b0; i_host_req = 1'b0; i_host_we = 1'b0;
    i_vid_addr = '0; i_host_addr = '0; i_host_din = '0;
    force_busy = 1'b0; model_en = 1'b1;
    #2 i_rstn = 1'b0;
    #1;
    chk("rst_state", {30'd0, o_state}, 32'd0);
    chk("rst_ctrl", {23'd0, o_vid_ack, o_vid_valid, o_host_ack, o_host_valid,
                     o_psram_stb, o_psram_we, o_err}, 32'd0);
    chk("rst_data", {o_vid_data, o_host_data}, 32'd0);
    repeat (3) @(posedge i_clk);
    @(negedge i_clk) i_rstn = 1'b1;

    // Host write: completion pulses valid, host data untouched
    push_txn(1'b1, 1'b1, 24'h000010, 16'h8765, 16'h0000);
    host_txn(1'b1, 24'h000010, 16'h8765, 50);
    // Host read-back
    push_txn(1'b1, 1'b0, 24'h000010, 16'h0000, 16'h8765);
    host_txn(1'b0, 24'h000010, 16'h0000, 50);
    chk("vid_data_untouched", {16'd0, o_vid_data}, 32'd0);
    // Video read
    push_txn(1'b0, 1'b0, 24'h000020, 16'h0000, 16'h20A5);
    vid_txn(24'h000020);
    chk("host_data_untouched", {16'd0, o_host_data}, 32'h8765);

    // Busy gating in IDLE
    push_txn(1'b1, 1'b0, 24'h000010, 16'h0000, 16'h8765);
    force_busy = 1'b1;
    i_host_req = 1'b1; i_host_we = 1'b0; i_host_addr = 24'h000010;
    seen = 1'b0;
    repeat (5) begin
      @(posedge i_clk); #1;
      if (o_host_ack) seen = 1'b1;
    end
    chk("no_ack_while_busy", {31'd0, seen}, 32'd0);
    force_busy = 1'b0;
    @(posedge i_clk); #1;
    chk("ack_after_busy_drop", {31'd0, o_host_ack}, 32'd1);
    i_host_req = 1'b0;
    wait_valid(1'b1, 50);

    // Contention: V,V,V,V,H,V,V,V,V,H
    for (int r = 0; r < 2; r++) begin
      for (int v = 0; v < 4; v++) push_txn(1'b0, 1'b0, 24'h000020, 16'h0000, 16'h20A5);
      push_txn(1'b1, 1'b0, 24'h000010, 16'h0000, 16'h8765);
    end
    i_vid_addr = 24'h000020; i_host_addr = 24'h000010; i_host_we = 1'b0;
    i_vid_req = 1'b1; i_host_req = 1'b1;
    acks = 0; n = 0;
    while (acks < 10 && n < 200) begin
      @(posedge i_clk); #1;
      n++;
      if (o_vid_ack || o_host_ack) acks++;
    end
    i_vid_req = 1'b0; i_host_req = 1'b0;
    chk("contention_acks", acks, 32'd10);
    wait_valid(1'b1, 50);

    // Timeout: controller never responds
    model_en = 1'b0;
    push_txn(1'b1, 1'b0, 24'h000040, 16'h0000, 16'h0000);
    @(negedge i_clk);
    s0 = stb_total;
    host_txn(1'b0, 24'h000040, 16'h0000, 1100);
    chk("timeout_stb_cycles", stb_total - s0, 32'd1023);
    chk("timeout_err", {31'd0, o_err}, 32'd1);
    chk("timeout_stb_low", {31'd0, o_psram_stb}, 32'd0);
    model_en = 1'b1;
    push_txn(1'b0, 1'b0, 24'h000020, 16'h0000, 16'h20A5);
    vid_txn(24'h000020);
    chk("err_sticky", {31'd0, o_err}, 32'd1);

    // Reset in WAIT_DONE with a pending video request
    grant_q.push_back(1'b0);
    psram_q.push_back('{we: 1'b0, addr: 24'h000030, din: 16'h0000});
    i_vid_req = 1'b1; i_vid_addr = 24'h000030;
    wait_ack(1'b0);
    i_vid_req = 1'b0;
    n = 0;
    while (o_state != 2'd2 && n < 20) begin
      @(posedge i_clk); #1;
      n++;
    end
    chk("reached_wait_done", {30'd0, o_state}, 32'd2);
    i_vid_req = 1'b1;
    i_rstn = 1'b0;
    #1;
    chk("midop_rst_state", {30'd0, o_state}, 32'd0);
    chk("midop_rst_ctrl", {23'd0, o_vid_ack, o_vid_valid, o_host_ack, o_host_valid,
                           o_psram_stb, o_psram_we, o_err}, 32'd0);
    chk("midop_rst_data", {o_vid_data, o_host_data}, 32'd0);
    chk("midop_rst_bus", {o_psram_addr, 8'd0} | {16'd0, o_psram_din}, 32'd0);
    repeat (4) @(posedge i_clk);
    push_txn(1'b0, 1'b0, 24'h000030, 16'h0000, 16'h30A5);
    @(negedge i_clk) i_rstn = 1'b1;
    wait_ack(1'b0);
    i_vid_req = 1'b0;
    wait_valid(1'b0, 50);

    repeat (5) @(posedge i_clk);
    #1;
    chk("drained_grants", grant_q.size(), 32'd0);
    chk("drained_psram", psram_q.size(), 32'd0);
    chk("drained_resp", host_q.size() + vid_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
